// File: rtl/period_meter_pkg.sv
// Shared types and helpers for the period meter.
// Holds the FSM state encoding and the result-width function.
package period_meter_pkg;

    typedef enum logic {
        IDLE,
        MEASURE
    } state_e;

    function automatic int cw_of(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input.
// Emits one-cycle rise/fall pulses on the synchronized level.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   cur;

    assign cur = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            prev_q <= cur;
        end
    end

    assign rise_o = cur & ~prev_q;
    assign fall_o = ~cur & prev_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow square wave in clk_in cycles.
// Optional 4-period sliding average of period: PERIOD_METER_AVG4_EN.
module period_meter
    import period_meter_pkg::*;
#(
    parameter  int MAX_COUNT   = 400000,
    parameter  int SYNC_STAGES = 2,
    localparam int CW          = cw_of(MAX_COUNT)
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          sig_in,
    input  logic          meas_ready,
    output logic          meas_valid,
    output logic [CW-1:0] period,
    output logic [CW-1:0] high_time,
    output logic          timeout,
    output logic          overrun
);

    localparam logic [CW-1:0] MAXC = CW'(MAX_COUNT);

    logic rise, fall;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i (clk_in),
        .rst_ni(reset),
        .sig_i (sig_in),
        .rise_o(rise),
        .fall_o(fall)
    );

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] hi_q, hi_d;
    logic          hi_seen_q, hi_seen_d;
    logic          timeout_q, timeout_d;
    logic          res_stb, tmo_stb;
    logic [CW-1:0] res_period, res_high;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            hi_seen_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            hi_seen_q <= hi_seen_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        hi_seen_d  = hi_seen_q;
        timeout_d  = timeout_q;
        res_stb    = 1'b0;
        tmo_stb    = 1'b0;
        res_period = cnt_q;
        // A period with no fall reports a 100% high time.
        res_high   = hi_seen_q ? hi_q : cnt_q;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d   = MEASURE;
                    cnt_d     = CW'(1);
                    hi_seen_d = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            MEASURE: begin
                if (rise) begin
                    res_stb   = 1'b1;
                    cnt_d     = CW'(1);
                    hi_seen_d = 1'b0;
                end else if (cnt_q == MAXC) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    tmo_stb   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (fall) begin
                        hi_d      = cnt_q;
                        hi_seen_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic          out_stb;
    logic [CW-1:0] out_per;

`ifdef PERIOD_METER_AVG4_EN
    logic [CW-1:0] w0_q, w1_q, w2_q;
    logic [1:0]    fill_q;
    logic [CW+1:0] sum;

    assign sum     = (CW+2)'(res_period) + (CW+2)'(w0_q)
                   + (CW+2)'(w1_q) + (CW+2)'(w2_q);
    assign out_stb = res_stb && (fill_q == 2'd3);
    assign out_per = sum[CW+1:2];

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            w0_q   <= '0;
            w1_q   <= '0;
            w2_q   <= '0;
            fill_q <= '0;
        end else if (tmo_stb) begin
            w0_q   <= '0;
            w1_q   <= '0;
            w2_q   <= '0;
            fill_q <= '0;
        end else if (res_stb) begin
            w2_q <= w1_q;
            w1_q <= w0_q;
            w0_q <= res_period;
            if (fill_q != 2'd3) begin
                fill_q <= fill_q + 2'd1;
            end
        end
    end
`else
    assign out_stb = res_stb;
    assign out_per = res_period;
`endif

    logic          valid_q, valid_d;
    logic [CW-1:0] per_q, per_d;
    logic [CW-1:0] high_q, high_d;
    logic          ovr_q, ovr_d;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            per_q   <= '0;
            high_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            per_q   <= per_d;
            high_q  <= high_d;
            ovr_q   <= ovr_d;
        end
    end

    // A new result may replace the pending one only when it leaves this cycle.
    always_comb begin
        valid_d = valid_q;
        per_d   = per_q;
        high_d  = high_q;
        ovr_d   = ovr_q;
        if (out_stb && (!valid_q || meas_ready)) begin
            valid_d = 1'b1;
            per_d   = out_per;
            high_d  = res_high;
        end else if (out_stb) begin
            ovr_d = 1'b1;
        end else if (valid_q && meas_ready) begin
            valid_d = 1'b0;
        end
    end

    assign meas_valid = valid_q;
    assign period     = per_q;
    assign high_time  = high_q;
    assign timeout    = timeout_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter with MAX_COUNT=20, SYNC_STAGES=2.
// Under PERIOD_METER_AVG4_EN only reset and averaging scenarios run.
module tb_period_meter;

    localparam int MAXC = 20;
    localparam int SS   = 2;
    localparam int CW   = 5;

    logic          clk_in = 1'b0;
    logic          reset = 1'b0;
    logic          sig_in = 1'b0;
    logic          meas_ready = 1'b0;
    logic          meas_valid;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          timeout;
    logic          overrun;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int q_per[$];
    int q_high[$];
    int q_cyc[$];

    period_meter #(
        .MAX_COUNT  (MAXC),
        .SYNC_STAGES(SS)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .sig_in    (sig_in),
        .meas_ready(meas_ready),
        .meas_valid(meas_valid),
        .period    (period),
        .high_time (high_time),
        .timeout   (timeout),
        .overrun   (overrun)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
        cyc++;
        if (meas_valid && meas_ready) begin
            q_per.push_back(int'(period));
            q_high.push_back(int'(high_time));
            q_cyc.push_back(cyc);
        end
    endtask

    task automatic clr();
        cyc = 0;
        q_per.delete();
        q_high.delete();
        q_cyc.delete();
    endtask

    task automatic do_reset();
        sig_in     = 1'b0;
        meas_ready = 1'b0;
        reset      = 1'b0;
        repeat (3) @(posedge clk_in);
        #1 reset = 1'b1;
        clr();
    endtask

    task automatic run(input int hi, input int lo, input int nper, input int tail);
        for (int p = 0; p < nper; p++) begin
            for (int c = 0; c < hi + lo; c++) begin
                sig_in = (c < hi);
                step();
            end
        end
        for (int t = 0; t < tail; t++) begin
            sig_in = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({meas_valid, timeout, overrun} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000", {meas_valid, timeout, overrun});
        end
        checks++;
        if ({period, high_time} !== '0) begin
            failures++;
            $display("FAIL reset_data got=%0d/%0d exp=0/0", period, high_time);
        end
    endtask

    task automatic test_divider();
        do_reset();
        meas_ready = 1'b1;
        run(4, 4, 6, 6);
        checks++;
        if (q_cyc.size() !== 5) begin
            failures++;
            $display("FAIL div_count got=%0d exp=5", q_cyc.size());
        end
        foreach (q_cyc[i]) begin
            checks++;
            if (q_per[i] !== 8 || q_high[i] !== 4 || q_cyc[i] !== 11 + 8 * i) begin
                failures++;
                $display("FAIL div_res%0d got=%0d/%0d@%0d exp=8/4@%0d",
                         i, q_per[i], q_high[i], q_cyc[i], 11 + 8 * i);
            end
        end
    endtask

    task automatic test_manual();
        do_reset();
        meas_ready = 1'b1;
        run(3, 7, 4, 6);
        checks++;
        if (q_cyc.size() !== 3) begin
            failures++;
            $display("FAIL man_count got=%0d exp=3", q_cyc.size());
        end
        foreach (q_cyc[i]) begin
            checks++;
            if (q_per[i] !== 10 || q_high[i] !== 3 || q_cyc[i] !== 13 + 10 * i) begin
                failures++;
                $display("FAIL man_res%0d got=%0d/%0d@%0d exp=10/3@%0d",
                         i, q_per[i], q_high[i], q_cyc[i], 13 + 10 * i);
            end
        end
    endtask

    task automatic test_boundary();
        do_reset();
        meas_ready = 1'b1;
        run(10, 10, 2, 4);
        checks++;
        if (q_cyc.size() !== 1) begin
            failures++;
            $display("FAIL bnd_count got=%0d exp=1", q_cyc.size());
        end else begin
            checks++;
            if (q_per[0] !== MAXC || q_high[0] !== 10 || q_cyc[0] !== 23) begin
                failures++;
                $display("FAIL bnd_res got=%0d/%0d@%0d exp=20/10@23",
                         q_per[0], q_high[0], q_cyc[0]);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        meas_ready = 1'b1;
        sig_in = 1'b1;
        while (cyc < 40 && !timeout) begin
            if (cyc == 3) sig_in = 1'b0;
            step();
        end
        checks++;
        if (timeout !== 1'b1 || cyc !== SS + 1 + MAXC) begin
            failures++;
            $display("FAIL tmo_time got=%b@%0d exp=1@%0d", timeout, cyc, SS + 1 + MAXC);
        end
        checks++;
        if (q_cyc.size() !== 0) begin
            failures++;
            $display("FAIL tmo_noresult got=%0d exp=0", q_cyc.size());
        end
        clr();
        for (int c = 0; c < 24; c++) begin
            sig_in = (c < 16) && ((c % 8) < 4);
            step();
            if (cyc == 2) begin
                checks++;
                if (timeout !== 1'b1) begin
                    failures++;
                    $display("FAIL tmo_hold got=%b exp=1", timeout);
                end
            end
            if (cyc == 3) begin
                checks++;
                if (timeout !== 1'b0) begin
                    failures++;
                    $display("FAIL tmo_clear got=%b exp=0", timeout);
                end
            end
        end
        checks++;
        if (q_cyc.size() !== 1 || q_per[0] !== 8 || q_high[0] !== 4 || q_cyc[0] !== 11) begin
            failures++;
            $display("FAIL tmo_next got=n%0d exp=n1 period 8 high 4 at 11", q_cyc.size());
        end
    endtask

    task automatic test_overrun();
        do_reset();
        meas_ready = 1'b0;
        run(4, 4, 1, 0);
        run(3, 5, 1, 0);
        checks++;
        if ({meas_valid, overrun} !== 2'b10 || period !== 5'd8 || high_time !== 5'd4) begin
            failures++;
            $display("FAIL ovr_first got=v%b o%b %0d/%0d exp=v1 o0 8/4",
                     meas_valid, overrun, period, high_time);
        end
        run(4, 4, 1, 6);
        checks++;
        if ({meas_valid, overrun} !== 2'b11 || period !== 5'd8 || high_time !== 5'd4) begin
            failures++;
            $display("FAIL ovr_drop got=v%b o%b %0d/%0d exp=v1 o1 8/4",
                     meas_valid, overrun, period, high_time);
        end
        meas_ready = 1'b1;
        step();
        checks++;
        if ({meas_valid, overrun} !== 2'b01) begin
            failures++;
            $display("FAIL ovr_xfer got=v%b o%b exp=v0 o1", meas_valid, overrun);
        end
        step();
        checks++;
        if ({meas_valid, overrun} !== 2'b01) begin
            failures++;
            $display("FAIL ovr_single got=v%b o%b exp=v0 o1", meas_valid, overrun);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        meas_ready = 1'b0;
        run(4, 4, 3, 0);
        checks++;
        if ({meas_valid, overrun} !== 2'b11) begin
            failures++;
            $display("FAIL ares_pre got=v%b o%b exp=v1 o1", meas_valid, overrun);
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({meas_valid, timeout, overrun, period, high_time} !== '0) begin
            failures++;
            $display("FAIL ares_now got=v%b t%b o%b %0d/%0d exp=all 0",
                     meas_valid, timeout, overrun, period, high_time);
        end
        @(posedge clk_in);
        #1 reset = 1'b1;
        clr();
        meas_ready = 1'b1;
        run(4, 4, 2, 6);
        checks++;
        if (q_cyc.size() !== 1 || q_per[0] !== 8 || q_high[0] !== 4 || q_cyc[0] !== 11) begin
            failures++;
            $display("FAIL ares_first got=n%0d exp=n1 period 8 high 4 at 11", q_cyc.size());
        end
    endtask

    task automatic test_avg();
        do_reset();
        meas_ready = 1'b1;
        run(4, 4, 2, 0);
        run(6, 6, 2, 0);
        run(4, 4, 1, 6);
        checks++;
        if (q_cyc.size() !== 1) begin
            failures++;
            $display("FAIL avg_count got=%0d exp=1", q_cyc.size());
        end else begin
            checks++;
            if (q_per[0] !== 10 || q_high[0] !== 6 || q_cyc[0] !== 43) begin
                failures++;
                $display("FAIL avg_res got=%0d/%0d@%0d exp=10/6@43",
                         q_per[0], q_high[0], q_cyc[0]);
            end
        end
    endtask

    initial begin
        test_reset();
`ifdef PERIOD_METER_AVG4_EN
        test_avg();
`else
        test_divider();
        test_manual();
        test_boundary();
        test_timeout();
        test_overrun();
        test_async_reset();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
